// File: rtl/puf_pkg.sv
// Purpose: shared types and constants for the PUF host sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

  localparam int CW_DEFAULT = 8;
  localparam int RW_DEFAULT = 8;

  // Fibonacci LFSR feedback taps 8,6,5,4 (bit 7 is tap 8); maximal length, period 255.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Sequencer states. Prefixed so they cannot collide with the SETTLE/TIMEOUT parameters.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT_DONE,
    S_ACK,
    S_EMIT
  } state_t;

  // Shift toward the MSB; the XOR of the tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Purpose: 2-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; this is a plain level path.
// Ports: clk, rst (async active-high), d (async input), q (synchronised output).
module puf_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_host_sequencer.sv
// Purpose: host side of the PUF challenge/response handshake; sweeps N challenges per run.
// Latency: per step 1 + SETTLE + (done_s wait, max TIMEOUT) + ACK cycles, then the record is held in EMIT.
// Backpressure: out_ready low stalls in EMIT indefinitely with the record held and computer_ack low.
// Ports: clk, rst (async active-high); start, num_challenges (0 = 2^CW) start a run;
//        challenge/computer_ack drive the PUF, done/response come back from it (done is async);
//        out_valid/out_ready/out_challenge/out_response/out_timeout carry records; busy, run_done status.
// Build option: define PUF_SEQ_LFSR_EN to draw challenges from an 8-bit LFSR seeded with LFSR_SEED
//        instead of an incrementing counter starting at 0.
module puf_host_sequencer
  import puf_pkg::*;
#(
  parameter int CW      = CW_DEFAULT,
  parameter int RW      = RW_DEFAULT,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
`ifdef PUF_SEQ_LFSR_EN
  ,
  parameter logic [CW-1:0] LFSR_SEED = CW'(8'hA5)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_challenges,
  output logic [CW-1:0] challenge,
  input  logic          done,
  input  logic [RW-1:0] response,
  output logic          computer_ack,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_challenge,
  output logic [RW-1:0] out_response,
  output logic          out_timeout,
  output logic          busy,
  output logic          run_done
);

  // One timer serves both the settle count and the done/ack timeouts.
  localparam int TMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int TW   = $clog2(TMAX) + 1;

`ifdef PUF_SEQ_LFSR_EN
  localparam logic [CW-1:0] CHAL_FIRST = LFSR_SEED;
`else
  localparam logic [CW-1:0] CHAL_FIRST = '0;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW:0]   count_q, count_d;   // one extra bit so 2^CW fits
  logic [CW-1:0] chal_d, out_chal_d;
  logic [RW-1:0] out_resp_d;
  logic          out_to_d, run_done_d;
  logic          done_s;

  puf_sync2 #(.W(1)) u_done_sync (
    .clk (clk),
    .rst (rst),
    .d   (done),
    .q   (done_s)
  );

  function automatic logic [CW-1:0] chal_advance(input logic [CW-1:0] c);
`ifdef PUF_SEQ_LFSR_EN
    return CW'(lfsr_next(8'(c)));
`else
    return c + CW'(1);
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_d    = count_q;
    chal_d     = challenge;
    out_chal_d = out_challenge;
    out_resp_d = out_response;
    out_to_d   = out_timeout;
    run_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = (num_challenges == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, num_challenges};
          chal_d  = CHAL_FIRST;
          timer_d = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Full settle time regardless of done_s, so a stale done cannot be mistaken for a response.
        if (timer_q == TW'(SETTLE - 1)) begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + TW'(1);
        if (done_s) begin
          out_chal_d = challenge;
          out_resp_d = response;
          out_to_d   = 1'b0;
          timer_d    = '0;
          state_d    = S_ACK;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          out_chal_d = challenge;
          out_resp_d = '0;
          out_to_d   = 1'b1;
          timer_d    = '0;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        if (!done_s) begin
          state_d = S_EMIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // done stuck high: flag the record but keep the response already captured.
          out_to_d = 1'b1;
          state_d  = S_EMIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EMIT: begin
        // out_valid is always high in EMIT, so out_ready alone completes the handshake.
        if (out_ready) begin
          count_d = count_q - (CW + 1)'(1);
          if (count_q == (CW + 1)'(1)) begin
            run_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            chal_d  = chal_advance(challenge);
            timer_d = '0;
            state_d = S_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      count_q       <= '0;
      challenge     <= CHAL_FIRST;
      out_challenge <= '0;
      out_response  <= '0;
      out_timeout   <= 1'b0;
      computer_ack  <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      challenge     <= chal_d;
      out_challenge <= out_chal_d;
      out_response  <= out_resp_d;
      out_timeout   <= out_to_d;
      // Registered from the next state so the PUF-facing and stream outputs are glitch-free.
      computer_ack  <= (state_d == S_ACK);
      out_valid     <= (state_d == S_EMIT);
      busy          <= (state_d != S_IDLE);
      run_done      <= run_done_d;
    end
  end

endmodule

// File: tb/tb_puf_host_sequencer.sv
module tb_puf_host_sequencer;

  localparam int CW      = 8;
  localparam int RW      = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_challenges;
  logic [CW-1:0] challenge;
  logic          done = 1'b0;
  logic [RW-1:0] response = '0;
  logic          computer_ack;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_challenge;
  logic [RW-1:0] out_response;
  logic          out_timeout;
  logic          busy;
  logic          run_done;

  always #5 clk = ~clk;

  puf_host_sequencer #(
    .CW(CW), .RW(RW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_challenges(num_challenges),
    .challenge(challenge), .done(done), .response(response),
    .computer_ack(computer_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_challenge(out_challenge), .out_response(out_response),
    .out_timeout(out_timeout), .busy(busy), .run_done(run_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters, sampled mid-cycle.
  int   ack_rises = 0;
  int   run_dones = 0;
  logic ack_prev  = 1'b0;
  always @(negedge clk) begin
    if (computer_ack && !ack_prev) ack_rises++;
    ack_prev = computer_ack;
    if (run_done) run_dones++;
  end

  // PUF model. mode 0: done ~10 cycles after a new challenge, response = ~challenge,
  // done drops on computer_ack. mode 1: never answers. mode 2: answers, never drops done.
  int        puf_mode  = 0;
  logic [7:0] last_chal = '0;
  int        cnt       = 0;
  bit        armed     = 1'b0;
  logic      busy_prev = 1'b0;
  always @(negedge clk) begin
    if (!busy) armed = 1'b0;
    else if (challenge !== last_chal || !busy_prev) begin
      armed = 1'b1;
      cnt   = 0;
    end else if (cnt < 1000) cnt++;
    last_chal = challenge;
    busy_prev = busy;
    case (puf_mode)
      0: begin
        if (computer_ack) done = 1'b0;
        else if (armed && cnt >= 10) begin
          done = 1'b1; response = ~challenge; armed = 1'b0;
        end
      end
      1: done = 1'b0;
      default: begin
        if (armed && cnt >= 10) begin
          done = 1'b1; response = ~challenge; armed = 1'b0;
        end
      end
    endcase
  end

  function automatic logic [7:0] first_chal();
`ifdef PUF_SEQ_LFSR_EN
    return 8'hA5;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] next_chal(input logic [7:0] c);
`ifdef PUF_SEQ_LFSR_EN
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
`else
    return c + 8'd1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    num_challenges = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for a record, sample it, then let the handshake edge pass.
  task automatic get_rec(input int budget, output logic [7:0] c, output logic [7:0] r,
                         output logic t);
    int k = 0;
    while (out_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("rec_valid", 32'(out_valid), 32'd1);
    c = out_challenge;
    r = out_response;
    t = out_timeout;
    tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    chk("idle", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, r, e, ne, f, fn;
    logic       t;
    int         a0, r0, err, bad, k;

    rst = 1'b1; start = 1'b0; num_challenges = '0; out_ready = 1'b1;
    f  = first_chal();
    fn = ~f;
    repeat (3) tick();

    // Reset state
    chk("rst_challenge", 32'(challenge), 32'(f));
    chk("rst_ack",       32'(computer_ack), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_run_done",  32'(run_done), 32'd0);
    chk("rst_out_chal",  32'(out_challenge), 32'd0);
    chk("rst_out_resp",  32'(out_response), 32'd0);
    chk("rst_out_to",    32'(out_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // 1: three normal steps
    a0 = ack_rises; r0 = run_dones;
    pulse_start(8'd3);
    chk("t1_busy_rise", 32'(busy), 32'd1);
    e = f;
    for (int i = 0; i < 3; i++) begin
      get_rec(200, c, r, t);
      ne = ~e;
      chk("t1_chal", 32'(c), 32'(e));
      chk("t1_resp", 32'(r), 32'(ne));
      chk("t1_to",   32'(t), 32'd0);
      e = next_chal(e);
    end
    wait_idle();
    chk("t1_run_done_once", 32'(run_dones - r0), 32'd1);
    chk("t1_ack_per_step",  32'(ack_rises - a0), 32'd3);

    // 2: PUF never answers; record valid in cycle 2+SETTLE+TIMEOUT counting the start cycle as 1
    puf_mode = 1;
    repeat (4) tick();
    a0 = ack_rises;
    pulse_start(8'd1);
    repeat (20) tick();
    chk("t2_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("t2_valid_at", 32'(out_valid), 32'd1);
    chk("t2_chal", 32'(out_challenge), 32'(f));
    chk("t2_resp", 32'(out_response), 32'd0);
    chk("t2_to",   32'(out_timeout), 32'd1);
    chk("t2_ack_once", 32'(ack_rises - a0), 32'd1);
    tick();
    wait_idle();

    // 3: done stuck high after ack -> ACK timeout keeps captured response
    puf_mode = 2;
    a0 = ack_rises;
    pulse_start(8'd1);
    get_rec(200, c, r, t);
    chk("t3_chal", 32'(c), 32'(f));
    chk("t3_resp", 32'(r), 32'(fn));
    chk("t3_to",   32'(t), 32'd1);
    chk("t3_ack_once", 32'(ack_rises - a0), 32'd1);
    wait_idle();
    puf_mode = 1;
    repeat (4) tick();

    // 4: downstream stall for 50 cycles
    puf_mode = 0;
    a0 = ack_rises;
    out_ready = 1'b0;
    pulse_start(8'd2);
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("t4_valid", 32'(out_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_challenge !== f || out_response !== fn ||
          out_timeout !== 1'b0 || challenge !== f || computer_ack !== 1'b0) bad++;
    end
    chk("t4_stall_stable", 32'(bad), 32'd0);
    chk("t4_no_extra_ack", 32'(ack_rises - a0), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t4_valid_drop", 32'(out_valid), 32'd0);
    get_rec(200, c, r, t);
    e  = next_chal(f);
    ne = ~e;
    chk("t4_chal2", 32'(c), 32'(e));
    chk("t4_resp2", 32'(r), 32'(ne));
    wait_idle();

    // 5: num_challenges = 0 -> 256 records with wrap, mid-run starts ignored
    a0 = ack_rises; r0 = run_dones;
    pulse_start(8'd0);
    e = f; err = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100 || i == 200) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      get_rec(200, c, r, t);
      ne = ~e;
      if (c !== e || r !== ne || t !== 1'b0) err++;
      e = next_chal(e);
    end
    chk("t5_records", 32'(err), 32'd0);
    wait_idle();
    chk("t5_run_done_once", 32'(run_dones - r0), 32'd1);
    chk("t5_ack_count", 32'(ack_rises - a0), 32'd256);

    // 6: reset during WAIT_DONE
    pulse_start(8'd5);
    get_rec(200, c, r, t);
    get_rec(200, c, r, t);
    puf_mode = 1;
    repeat (8) tick();
    chk("t6_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_chal",  32'(challenge), 32'(f));
    chk("t6_async_busy",  32'(busy), 32'd0);
    chk("t6_async_ack",   32'(computer_ack), 32'd0);
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_ochal", 32'(out_challenge), 32'd0);
    chk("t6_async_oresp", 32'(out_response), 32'd0);
    chk("t6_async_oto",   32'(out_timeout), 32'd0);
    tick();
    rst = 1'b0;
    puf_mode = 0;
    repeat (3) tick();
    chk("t6_no_record", 32'(out_valid), 32'd0);
    pulse_start(8'd1);
    get_rec(200, c, r, t);
    chk("t6_restart_chal", 32'(c), 32'(f));
    chk("t6_restart_resp", 32'(r), 32'(fn));
    chk("t6_restart_to",   32'(t), 32'd0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_host_sequencer.md
Name: puf_host_sequencer

Overview:
- Host-side end of the serial PUF challenge/response handshake. It drives `challenge`, waits for the PUF `done`, captures `response`, then holds `computer_ack` until `done` drops.
- It sweeps a programmable number of challenges in one run.
- Each (challenge, response, timeout) record goes out on a valid/ready stream for a UART or logger block.
- It sits beside the PUF in the S7 top level and replaces the external computer for on-board characterisation.

Parameters:
- CW, 8, challenge width.
- RW, 8, response width.
- SETTLE, 4, cycles the challenge is held stable before the PUF is expected to respond (≥1).
- TIMEOUT, 1024, max cycles spent waiting for `done` (or for `done` to fall) before the step is aborted.
- LFSR_SEED, 8'hA5, nonzero seed used only when the optional feature is compiled in.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a run when idle, ignored otherwise.
- num_challenges, input, CW, challenges per run; sampled at start; 0 means 2^CW.
- challenge, output, CW, challenge to the PUF.
- done, input, 1, PUF done; asynchronous, 2-flop synchronised internally.
- response, input, RW, PUF response; stable while done is high.
- computer_ack, output, 1, acknowledge/reset request to the PUF.
- out_valid, output, 1, record valid.
- out_ready, input, 1, downstream accepts record.
- out_challenge, output, CW, challenge of the record.
- out_response, output, RW, captured response (0 on timeout).
- out_timeout, output, 1, record produced by timeout.
- busy, output, 1, high from the cycle after start until return to IDLE.
- run_done, output, 1, one-cycle pulse when the last record is accepted.

Behaviour:
- Reset values:
  - challenge = 0 (LFSR_SEED when the feature is on); computer_ack = 0.
  - out_valid = 0; out_challenge = 0; out_response = 0; out_timeout = 0.
  - busy = 0; run_done = 0; state = IDLE; synchroniser flops = 0.
  - Reset mid-run aborts immediately; no record is emitted.
- done_s is done after 2 flops. All decisions use done_s, so there is 2 cycles of latency from the pin.
- FSM:
  - IDLE:
    - On start, latch count (0 → 2^CW) and load the first challenge; go to SETTLE.
    - busy rises the next cycle.
  - SETTLE:
    - Count SETTLE cycles with challenge constant, then go to WAIT_DONE.
    - If done_s is already high on entry, still wait SETTLE cycles.
  - WAIT_DONE:
    - Timer starts at 0.
    - done_s high: register response into out_response, out_timeout = 0, go to ACK.
    - Timer reaches TIMEOUT-1 first: out_response = 0, out_timeout = 1, go to ACK.
  - ACK:
    - computer_ack = 1; the timer restarts.
    - Stay until done_s = 0 or the timer expires. On expiry, set out_timeout = 1 and keep the captured response.
    - computer_ack drops on exit. Go to EMIT.
  - EMIT:
    - out_valid = 1 with the record held stable until out_ready.
    - out_valid ∧ out_ready: decrement the count.
      - Count was 1: pulse run_done and go to IDLE.
      - Otherwise: advance the challenge and go to SETTLE.
    - out_valid deasserts in the cycle after the handshake.
- The challenge changes only on the EMIT→SETTLE transition.
  - Counter mode: +1 mod 2^CW; 8'hFF wraps to 8'h00.
- start while busy is ignored.
- out_ready held low stalls indefinitely in EMIT. computer_ack is already low during the stall, and no PUF stimulus changes.
- A done glitch shorter than 2 cycles may be missed. This is acceptable; the timeout covers it.

Optional Feature:
- Macro: PUF_SEQ_LFSR_EN.
- Defined:
  - Challenges come from a Fibonacci LFSR: CW=8, taps 8,6,5,4, seeded with LFSR_SEED at start.
  - Period 255; the all-zero state is never produced.
- Undefined: incrementing counter starting at 0 each run.

Decomposition:
- Shared package puf_pkg:
  - state enum (IDLE, SETTLE, WAIT_DONE, ACK, EMIT);
  - default CW/RW;
  - LFSR tap constant.
- One natural sub-module: puf_sync2, a 2-flop synchroniser with async active-high reset, reused for done and for future host inputs.

Test Plan:
- num_challenges=3, counter mode, model PUF asserts done 10 cycles after challenge with response = ~challenge → records (00,FF,0), (01,FE,0), (02,FD,0). Also: run_done pulses once; computer_ack high ≥1 cycle per step; busy low afterwards.
- PUF never asserts done, TIMEOUT=16 → record (00,00,1) appears exactly 2+SETTLE+16 cycles after start + ACK exit; computer_ack pulses once.
- PUF holds done high after ack → ACK timeout; record carries the captured response with out_timeout=1.
- out_ready held low 50 cycles during EMIT → out_valid and the record stay stable, challenge is unchanged, and there is no extra computer_ack.
- num_challenges=0 → 256 records; challenge wraps FF→00 inside one run; start pulses mid-run are ignored.
- rst asserted during WAIT_DONE → all outputs reach reset values asynchronously; the next start restarts at challenge 00 (or A5, then the LFSR sequence, with PUF_SEQ_LFSR_EN).
